// File: rtl/keypoint_reader.sv
// keypoint_reader: drains the keypoint BRAM onto a valid/ready stream through a credit-limited skid FIFO.
// Define KEYPOINT_SCALE_EN to map octave-1 coordinates to top-octave pixels (shift left by 1).
module keypoint_reader #(
  parameter int DIMENSION = 64,
  parameter int KEY_DEPTH = 4096,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int W = $clog2(DIMENSION),
  localparam int AW = $clog2(KEY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          start,
  input  logic [AW-1:0] key_count,
  output logic [AW-1:0] key_read_addr,
  input  logic [2*W:0]  key_data,
  output logic          kp_valid,
  input  logic          kp_ready,
  output logic [W-1:0]  kp_x,
  output logic [W-1:0]  kp_y,
  output logic          kp_octave,
  output logic          kp_last,
  output logic          busy,
  output logic          done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_DRAIN, S_DONE} state_t;
  state_t state, nxt;
  logic [AW:0] cnt, ptr, out_cnt, req;
  logic [READ_LATENCY-1:0] vld;
  logic [CW-1:0] inflight, occ;
  logic [PW-1:0] wr, rd;
  logic [2*W:0] mem [FIFO_DEPTH];
  logic [2*W:0] head;
  logic [W-1:0] x, y;
  logic issue, push, pop;
  assign req = ({1'b0, key_count} > (AW+1)'(KEY_DEPTH)) ? (AW+1)'(KEY_DEPTH) : {1'b0, key_count};
  assign push = vld[READ_LATENCY-1];
  assign pop = kp_valid & kp_ready;
  assign kp_valid = occ != '0;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = req != '0 ? S_RD : S_DONE;
      S_RD:    if (ptr + (AW+1)'(issue) == cnt) nxt = S_DRAIN;
      S_DRAIN: if (inflight == '0 && occ == '0) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  // Address 0 is already presented in IDLE, so the first read goes out with the start pulse.
  always_comb begin
    issue = state == S_IDLE ? start && req != '0
          : state == S_RD && ptr < cnt && int'(inflight) + int'(occ) < FIFO_DEPTH;
    busy = state != S_IDLE;
    key_read_addr = state == S_IDLE ? '0 : ptr[AW-1:0];
  end
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      vld <= '0;
      inflight <= '0;
      occ <= '0;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      ptr <= '0;
      out_cnt <= '0;
      done <= 1'b0;
    end else begin
      vld <= READ_LATENCY'({vld, issue});
      inflight <= inflight + CW'(issue) - CW'(push);
      occ <= occ + CW'(push) - CW'(pop);
      if (push) wr <= wr == PW'(FIFO_DEPTH - 1) ? '0 : wr + 1'b1;
      if (pop) rd <= rd == PW'(FIFO_DEPTH - 1) ? '0 : rd + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
      if (state == S_IDLE && start) begin
        cnt <= req;
        ptr <= (AW+1)'(issue);
        out_cnt <= '0;
      end else if (issue) ptr <= ptr + 1'b1;
      done <= state == S_DONE;
    end
  always_ff @(posedge clk)
    if (push) mem[wr] <= key_data;
  always_comb begin
`ifdef KEYPOINT_SCALE_EN
    x = head[2*W] ? {head[2*W-2:W], 1'b0} : head[2*W-1:W];
    y = head[2*W] ? {head[W-2:0], 1'b0} : head[W-1:0];
`else
    x = head[2*W-1:W];
    y = head[W-1:0];
`endif
    kp_x = kp_valid ? x : '0;
    kp_y = kp_valid ? y : '0;
    kp_octave = kp_valid & head[2*W];
    kp_last = kp_valid && out_cnt == cnt - 1'b1;
  end
endmodule

// File: tb/tb_keypoint_reader.sv
// tb_keypoint_reader: randomized bench for keypoint_reader against a queue-based reference model.
module tb_keypoint_reader;
  localparam int W = 6;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
  logic clk = 0, rst_in = 0, start = 0, kp_ready = 0;
  logic [AW-1:0] key_count = '0;
  logic [AW-1:0] key_read_addr;
  logic [2*W:0] key_data, p1, p2;
  logic kp_valid, kp_octave, kp_last, busy, done;
  logic [W-1:0] kp_x, kp_y;
  logic [2*W:0] bram [DEPTH];
  logic [2*W:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int beats, done_cnt, first_v, first_t, last_t, s_cyc;
  bit mon_en = 0, held_v = 0;
  logic [2*W+1:0] held;

  keypoint_reader dut (
    .clk(clk), .rst_in(rst_in), .start(start), .key_count(key_count),
    .key_read_addr(key_read_addr), .key_data(key_data), .kp_valid(kp_valid),
    .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y), .kp_octave(kp_octave),
    .kp_last(kp_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  // Two-cycle registered BRAM read port
  always @(posedge clk) begin
    p1 <= bram[key_read_addr];
    p2 <= p1;
    cyc <= cyc + 1;
  end
  assign key_data = p2;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] xform(logic [2*W:0] e);
    logic [W-1:0] x = e[2*W-1:W];
    logic [W-1:0] y = e[W-1:0];
`ifdef KEYPOINT_SCALE_EN
    if (e[2*W]) begin
      x = W'(x * 2);
      y = W'(y * 2);
    end
`endif
    return {e[2*W], x, y};
  endfunction

  always @(negedge clk) begin : mon
    logic [2*W:0] e;
    if (mon_en) begin
      if (held_v) begin
        chk("hold_valid", kp_valid, 1);
        chk("hold_data", {kp_last, kp_octave, kp_x, kp_y}, held);
      end
      if (kp_valid && first_v < 0) first_v = cyc;
      if (kp_valid && kp_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("kp_x", kp_x, e[2*W-1:W]);
          chk("kp_y", kp_y, e[W-1:0]);
          chk("kp_octave", kp_octave, e[2*W]);
          chk("kp_last", kp_last, exp_q.size() == 0);
        end
        if (beats == 0) first_t = cyc;
        last_t = cyc;
        beats++;
      end
      held_v = kp_valid && !kp_ready;
      held = {kp_last, kp_octave, kp_x, kp_y};
      if (done) done_cnt++;
    end
  end

  task automatic start_pass(int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(xform(bram[i]));
    beats = 0;
    done_cnt = 0;
    first_v = -1;
    held_v = 0;
    mon_en = 1;
    @(posedge clk);
    #1 start = 1;
    key_count = AW'(n);
    @(posedge clk);
    #1 start = 0;
    s_cyc = cyc;
  endtask

  task automatic finish_pass(int n, int mode, bit dbl);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      case (mode)
        0: kp_ready = 1;
        1: kp_ready = (t >= 6 && t < 16) ? 1'b0 : (t % 2 == 0);
        2: kp_ready = ($urandom % 4) != 0;
        default: kp_ready = $urandom % 2;
      endcase
      if (dbl && t == 2) begin
        start = 1;
        key_count = AW'(n + 5);
      end else if (dbl && t == 3) start = 0;
      @(posedge clk);
      #1 t++;
    end
    kp_ready = 1;
    repeat (4) @(posedge clk);
    #1 mon_en = 0;
    chk("timeout", t < 3000, 1);
    chk("beats", beats, n);
    chk("left_over", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] = '0;
    #1;
    chk("rst_valid", kp_valid, 0);
    chk("rst_out", {kp_x, kp_y, kp_octave, kp_last}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_addr", key_read_addr, 0);
    #20 rst_in = 1;
    kp_ready = 1;
    // Empty pass
    start_pass(0);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_done_early", done, 0);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    @(negedge clk);
    chk("t1_done_off", done, 0);
    mon_en = 0;
    chk("t1_beats", beats, 0);
    // Eight-entry ramp, full throughput
    for (int i = 0; i < 8; i++) bram[i] = {1'b0, 6'(i), 6'(63 - i)};
    start_pass(8);
    finish_pass(8, 0, 0);
    chk("first_lat", first_v - s_cyc, 2);
    chk("back_to_back", last_t - first_t, 7);
    // Toggled ready with a long stall
    start_pass(8);
    finish_pass(8, 1, 0);
    // Reset after three beats, then restart
    start_pass(8);
    for (int t = 0; beats < 3 && t < 50; t++) begin
      @(posedge clk);
      #1;
    end
    chk("t5_three_beats", beats, 3);
    #2 rst_in = 0;
    #1 mon_en = 0;
    chk("t5_valid", kp_valid, 0);
    chk("t5_out", {kp_x, kp_y, kp_octave, kp_last}, 0);
    chk("t5_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_in = 1;
    repeat (6) begin
      @(negedge clk);
      chk("t5_idle_valid", kp_valid, 0);
    end
    start_pass(8);
    finish_pass(8, 0, 0);
    // Second start and key_count change while busy
    start_pass(8);
    finish_pass(8, 2, 1);
    // Octave-1 entry scaling
    bram[0] = {1'b1, 6'd5, 6'd9};
    bram[1] = {1'b1, 6'd40, 6'd33};
    start_pass(2);
    finish_pass(2, 0, 0);
    // Random contents, lengths and backpressure
    repeat (8) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) bram[i] = 13'($urandom);
      start_pass(n);
      finish_pass(n, $urandom_range(0, 3), $urandom % 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
